// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: FSM state encoding and datapath widths.
package alu_arbiter_pkg;

  localparam int OPERAND_W = 64;
  localparam int INSTR_W   = 32;
  localparam int STAT_W    = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: returns the first asserted request at or after the
// pointer (wrapping), as a one-hot grant plus its binary index.
// Purely combinational so other arbiters can reuse it.
module rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int j;

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int off = 0; off < N; off++) begin
      // The pointer is always < N, so one subtraction is enough to wrap.
      j = int'(i_ptr) + off;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = IDX_W'(j);
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with round-robin
// arbitration. Operands are registered toward the ALU, the result is
// registered back and returned on a valid/ready channel tagged with the
// owning requester id.
// Optional build macro ALU_ARB_STATS_EN adds per-requester grant counters
// (stat_grants) and a response-stall counter (stat_stall).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*OPERAND_W-1:0] req_a,
  input  logic [NUM_REQ*OPERAND_W-1:0] req_b,
  input  logic [NUM_REQ*INSTR_W-1:0]   req_instruction,
  output logic [OPERAND_W-1:0]         alu_a,
  output logic [OPERAND_W-1:0]         alu_b,
  output logic [INSTR_W-1:0]           alu_instruction,
  input  logic [OPERAND_W-1:0]         alu_result,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [OPERAND_W-1:0]         rsp_data,
  output logic [ID_W-1:0]              rsp_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]    stat_grants,
  output logic [STAT_W-1:0]            stat_stall
`endif
);

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_grant_any;
  logic               w_grant_en;
  logic               w_handshake;
  logic [ID_W-1:0]    w_ptr_next;

  logic [OPERAND_W-1:0] w_a_arr   [NUM_REQ];
  logic [OPERAND_W-1:0] w_b_arr   [NUM_REQ];
  logic [INSTR_W-1:0]   w_ins_arr [NUM_REQ];

  // Unpack the flat request buses into per-requester lanes.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_a_arr[gi]   = req_a[gi*OPERAND_W +: OPERAND_W];
      assign w_b_arr[gi]   = req_b[gi*OPERAND_W +: OPERAND_W];
      assign w_ins_arr[gi] = req_instruction[gi*INSTR_W +: INSTR_W];
    end
  endgenerate

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_grant_any)
  );

  // A new op may start when idle, or when the current response is being
  // consumed this cycle (back-to-back issue).
  assign w_grant_en  = (r_state == IDLE) || ((r_state == RESP) && rsp_ready);
  assign req_ready   = w_grant_en ? w_grant : '0;
  assign w_handshake = w_grant_en && w_grant_any;
  assign w_ptr_next  = (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);

  // Arbitration FSM with registered ALU operands and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_id            <= '0;
      alu_a           <= '0;
      alu_b           <= '0;
      alu_instruction <= '0;
      rsp_valid       <= 1'b0;
      rsp_data        <= '0;
      rsp_id          <= '0;
    end else begin
      // Operands only move on a grant; otherwise they keep their last value.
      if (w_handshake) begin
        alu_a           <= w_a_arr[w_grant_idx];
        alu_b           <= w_b_arr[w_grant_idx];
        alu_instruction <= w_ins_arr[w_grant_idx];
        r_id            <= w_grant_idx;
        r_rr_ptr        <= w_ptr_next;
      end
      case (r_state)
        IDLE: begin
          if (w_handshake) r_state <= EXEC;
        end
        EXEC: begin
          rsp_data  <= alu_result;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= w_handshake ? EXEC : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [STAT_W-1:0] r_grant_cnt [NUM_REQ];
  logic [STAT_W-1:0] r_stall_cnt;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_stats
      // Count accepted requests per requester; wraps naturally at 2^32.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_grant_cnt[gi] <= '0;
        end else if (req_valid[gi] && req_ready[gi]) begin
          r_grant_cnt[gi] <= r_grant_cnt[gi] + STAT_W'(1);
        end
      end
      assign stat_grants[gi*STAT_W +: STAT_W] = r_grant_cnt[gi];
    end
  endgenerate

  // Count cycles where a finished result waits on the consumer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if ((r_state == RESP) && !rsp_ready) begin
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
    end
  end
  assign stat_stall = r_stall_cnt;
`endif

endmodule
